seg7_msg_scroller: RTL
======================

Name: seg7_msg_scroller

Overview:
Writer-side producer for the 4-digit seven-segment display driver. It holds a short message of display character codes in a small buffer. It drives the driver's packed 32-bit digit word `x` with a 4-character window that scrolls left at a programmable rate. The block sits between control logic (FSM or UART command path) and the display driver; its `x` output connects directly to the driver's `x` input.

Parameters:
DEPTH, 16, number of message buffer entries (power of 2)
AW, 4, address width, log2(DEPTH)
TICK_DIV, 25000000, clock cycles per scroll step (>=2)
CW, 25, tick counter width, must hold TICK_DIV-1
BLANK, 8'hA9, display code for an unlit digit

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
wr_en  in  1  write strobe for the message buffer
wr_addr  in  AW  buffer write address
wr_data  in  8  display character code to store (display code set: 00-0A, 0C, 0D, 1E, A0-A9)
msg_len  in  AW+1  number of valid characters; sampled on start
start  in  1  single-cycle pulse; begin or restart scrolling
stop  in  1  single-cycle pulse; stop scrolling and blank the display
x  out  32  packed digit codes; x[31:24] is the leftmost digit, x[7:0] the rightmost
busy  out  1  high while in RUN
wrap_pulse  out  1  one-cycle pulse when the scroll position wraps to 0

Behaviour:
- One clock domain. Reset is synchronous and active-high, named `reset`; the clock is named `clk`.
- Reset:
  - state=IDLE, pos=0, tick counter=0, len=0.
  - All buffer entries set to BLANK.
  - x=32'hA9A9A9A9, busy=0, wrap_pulse=0.
- Buffer:
  - When wr_en=1, buf[wr_addr]<=wr_data on the clock edge. Writes are accepted in any state.
  - Writes do not refresh x immediately; they become visible at the next x update.
- Effective sequence:
  - Period P = len + 4.
  - c(i) = buf[i] if i < len, else BLANK. The message is followed by a 4-blank gap before it repeats.
- Window:
  - x = {c(pos), c((pos+1) mod P), c((pos+2) mod P), c((pos+3) mod P)}.
  - x is a registered output, updated only on a start, a step, or a stop.
- States:
  - IDLE:
    - x holds BLANK in all four digits; busy=0.
    - start with msg_len>=1 -> RUN.
    - start with msg_len=0 is ignored.
  - RUN:
    - busy=1.
    - The tick counter increments every clock.
    - When the counter reaches TICK_DIV-1, it resets to 0, pos advances (P-1 wraps to 0), and x is reloaded from the new pos on the same edge.
    - On the wrap edge, wrap_pulse=1 for exactly one cycle.
- Start (from IDLE or RUN):
  - len <= min(msg_len, DEPTH); pos <= 0; counter <= 0.
  - x <= window at pos 0 on the same edge, so x is valid one cycle after start is sampled.
  - start in RUN restarts cleanly; wrap_pulse is not asserted.
- Stop (RUN -> IDLE): x <= 32'hA9A9A9A9, busy <= 0, counter cleared; takes effect on the next edge.
- Priority when events coincide: reset > stop > start > tick.
  - stop and start in the same cycle -> IDLE.
  - start coincident with a tick edge -> restart, with no step.
- msg_len > DEPTH is clamped to DEPTH.
- msg_len is ignored except in the cycle start is sampled.
- Reset mid-RUN: return to the reset values on the next edge, with no further steps.

Test Plan:
1. Assert reset for 2 cycles -> x=32'hA9A9A9A9, busy=0, wrap_pulse=0; all buffer entries read back as A9 after start with len=16.
2. TICK_DIV=4. Write buf[0..4]={A2,A3,A0,A5,A6} ("PrInt"), msg_len=5, pulse start ->
   - Next cycle: x=32'hA2A3A0A5, busy=1.
   - 4 clocks later: x=32'hA3A0A5A6.
   - 4 clocks after that: x=32'hA0A5A6A9.
3. Continue test 2 (P=9) -> after 9 steps x=32'hA2A3A0A5 again, with wrap_pulse high exactly one cycle on that edge; 0 wrap pulses at any other step.
4. TICK_DIV=4. buf[0..1]={01,02}, msg_len=2, start -> x=32'h0102A9A9. Next step -> x=32'h02A9A9A9. Overwrite buf[0]=08 mid-run -> new value appears only at the next step containing index 0.
5. Start with msg_len=0 in IDLE -> busy stays 0, x unchanged. In RUN, stop and start in the same cycle -> IDLE, x=32'hA9A9A9A9. msg_len=20 -> len clamps to 16, P=20.
6. Assert reset mid-RUN at counter=2 -> next cycle x=32'hA9A9A9A9, busy=0; no further steps or wrap_pulse until a new start.

Source files
------------

// File: rtl/seg7_msg_scroller.sv
// seg7_msg_scroller: message buffer feeding a 4-digit window that scrolls left at a programmable rate
module seg7_msg_scroller #(
    parameter int DEPTH = 16,
    parameter int AW = 4,
    parameter int TICK_DIV = 25000000,
    parameter int CW = 25,
    parameter logic [7:0] BLANK = 8'hA9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   msg_len,
    input  logic          start,
    input  logic          stop,
    output logic [31:0]   x,
    output logic          busy,
    output logic          wrap_pulse
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [7:0] mem [DEPTH];
    logic [AW:0] len, pos, pos_nx, clamp, wl, wp;
    logic [AW+1:0] idx, per;
    logic [CW-1:0] cnt;
    logic [31:0] win;
    logic go;
    assign go = start && msg_len != '0;
    assign clamp = msg_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : msg_len;
    assign pos_nx = pos == len + (AW+1)'(3) ? '0 : pos + 1'b1;
    // one window builder serves both a restart (pos 0, new length) and a step (next pos)
    always_comb begin
        wl = go ? clamp : len;
        wp = go ? '0 : pos_nx;
        per = {1'b0, wl} + (AW+2)'(4);
        win = '0;
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            idx = {1'b0, wp} + (AW+2)'(k);
            idx = idx >= per ? idx - per : idx;
            win[31-8*k -: 8] = idx < {1'b0, wl} ? mem[idx[AW-1:0]] : BLANK;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= BLANK;
            state <= IDLE;
            len <= '0;
            pos <= '0;
            cnt <= '0;
            x <= {4{BLANK}};
            busy <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            if (wr_en) mem[wr_addr] <= wr_data;
            wrap_pulse <= 1'b0;
            if (stop) begin
                state <= IDLE;
                cnt <= '0;
                x <= {4{BLANK}};
                busy <= 1'b0;
            end else if (go) begin
                state <= RUN;
                len <= clamp;
                pos <= '0;
                cnt <= '0;
                x <= win;
                busy <= 1'b1;
            end else if (state == RUN) begin
                if (cnt == CW'(TICK_DIV - 1)) begin
                    cnt <= '0;
                    pos <= pos_nx;
                    x <= win;
                    wrap_pulse <= pos_nx == '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
